adrv9001_tx_data_gen: RTL
=========================

# adrv9001_tx_data_gen

Transmit data source that sits directly upstream of the ADRV9001 transmit channel and drives its 32-bit IQ AXI-Stream input in the `dclk_div` domain. It passes user IQ samples through a registered skid stage, or replaces them with built-in test patterns: constant, ramp or PRBS15. In passthrough it detects underflow and can optionally fill gaps with zeros so the SSI link never starves. Underflow is reported as a sticky flag and a saturating beat count.

## Interface
Parameters:
- `ZERO_FILL`, 1, when 1 a passthrough underflow emits a zero word instead of dropping `m_axis_tvalid`.
- `PRBS_SEED`, 15'h7FFF, LFSR reload value; must be nonzero.

Ports:
- `clk`  in  1  single clock; connect to transmit `s_axis_aclk` (dclk_div).
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  2  0 passthrough, 1 constant, 2 ramp, 3 PRBS15.
- `const_iq`  in  32  constant-mode word, I in [31:16], Q in [15:0].
- `clear`  in  1  one-cycle pulse; clears `underflow_flag` and `underflow_cnt`.
- `s_axis_tdata`  in  32  user IQ, I in [31:16], Q in [15:0].
- `s_axis_tvalid`  in  1  user data valid.
- `s_axis_tready`  out  1  registered ready.
- `m_axis_tdata`  out  32  IQ to the transmit channel.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  transmit-channel ready.
- `underflow_flag`  out  1  sticky underflow indicator.
- `underflow_cnt`  out  16  saturating count of underflow cycles.

## Operation
- **Reset values** while `rst` is high:
  - `m_axis_tvalid` is 0, `m_axis_tdata` is 0, `s_axis_tready` is 0.
  - Underflow flag and count are 0, and `armed` is 0.
  - The ramp counter is 0 and the LFSR is loaded with `PRBS_SEED`.
  - The first cycle after reset release, `s_axis_tready` is 1.
- **Mode changes.** `mode` is sampled into `mode_q` at a beat boundary: when the output register is empty, or on an output transfer (`m_axis_tvalid & m_axis_tready`).
  - When `mode_q` changes, the ramp counter and the LFSR reload.
  - Skid contents are discarded.
  - `armed` clears.
- **Passthrough (0):** two-entry skid buffer, made of an output register plus a spare register.
  - `s_axis_tready` is 1 whenever the spare register is empty.
  - Data is never reordered, duplicated or dropped, except on a mode change.
- **Constant (1):** `m_axis_tvalid` is held at 1; `m_axis_tdata` follows `const_iq`, sampled on each beat.
- **Ramp (2):**
  - I = r and Q = ~r + 1 (two's-complement negation), where r is 16 bits.
  - r increments on each output transfer and wraps from 0xFFFF to 0x0000.
- **PRBS15 (3):**
  - Polynomial x^15+x^14+1, Fibonacci form, feedback = s[14]^s[13], shifted into s[0].
  - The LFSR advances 16 steps per output transfer. The 16 generated bits form I, with the first bit in I[15].
  - Q = ~I.
- In modes 1–3, `s_axis_tready` is held at 1 and input is discarded.
- **Underflow** is evaluated in passthrough only:
  - `armed` sets on the first accepted input beat.
  - An underflow cycle is one where `armed`, `m_axis_tready` is 1, and neither skid register holds data.
  - On each underflow cycle the flag sets and the count increments, saturating at 0xFFFF.
  - If `ZERO_FILL` is 1, that cycle presents `m_axis_tvalid` = 1 with `m_axis_tdata` = 0, and the zero beat transfers.
  - If `ZERO_FILL` is 0, `m_axis_tvalid` is 0 on that cycle.
- **Simultaneous `clear` and underflow:** the underflow wins, so the flag ends at 1 and the count ends at 1.

## Timing
- Passthrough latency is 1 cycle from an input transfer to `m_axis_tvalid` (registered output).
- Sustained throughput is 1 beat per cycle with `m_axis_tready` held high.
- `m_axis_tdata` is stable while `m_axis_tvalid` is high and `m_axis_tready` is low; AXI-Stream rules apply.
- A generated pattern's first word appears 1 cycle after `mode_q` updates.
- `underflow_flag` and `underflow_cnt` update the cycle after the underflow cycle.
- Reset asserted mid-stream takes effect on the next edge; partial beats are not preserved.

## Structure
- **Package `adrv9001_tx_pkg`:**
  - Mode constants `TX_MODE_PASS`, `TX_MODE_CONST`, `TX_MODE_RAMP`, `TX_MODE_PRBS`.
  - IQ field positions (I MSB half).
  - The PRBS15 tap constants.
- **Sub-module `adrv9001_prbs15`:**
  - Holds the 16-step parallel LFSR, with ports `clk`, `rst`, `load`, `advance` and `dout[15:0]`.
  - Shared later by the receive-side checker.
- **Top level** holds the skid buffer, the `mode_q` boundary logic, the ramp counter and the underflow logic.

## Test plan
- **Passthrough burst:** 8 beats 0x00010002…0x00080010 with `m_axis_tready` toggling 1,0,1,… → the same 8 words appear in order, each stable while stalled, with no underflow.
- **Ramp:** mode=2 with `m_axis_tready`=1 →
  - words 0x00000000, 0x0001FFFF, 0x0002FFFE;
  - after 65536 beats the word is 0x00000000 again.
- **PRBS:** mode=3 →
  - 1000 words match the package reference model;
  - Q == ~I on every word;
  - a mode toggle 3→0→3 restarts from the seed word.
- **Underflow:** `ZERO_FILL`=1, 4 beats, then `s_axis_tvalid`=0 for 5 cycles with `m_axis_tready`=1 →
  - 5 zero words, `underflow_cnt`=5, flag=1;
  - then a `clear` pulse → 0/0.
- **No-fill underflow:** `ZERO_FILL`=0, same stimulus → `m_axis_tvalid`=0 for those 5 cycles and `underflow_cnt`=5.
- **Reset and constant mode:**
  - `rst` asserted mid-burst → on the next edge all outputs are 0 and the count is 0;
  - mode=1 with `const_iq`=0x7FFF8001 → a continuous stream of 0x7FFF8001.

Source files
------------

// File: rtl/adrv9001_tx_pkg.sv
// Shared definitions for the ADRV9001 transmit data source: mode encoding,
// IQ word layout and the PRBS15 generator step shared with the receive checker.
package adrv9001_tx_pkg;

  typedef enum logic [1:0] {
    TX_MODE_PASS  = 2'd0,
    TX_MODE_CONST = 2'd1,
    TX_MODE_RAMP  = 2'd2,
    TX_MODE_PRBS  = 2'd3
  } tx_mode_e;

  // IQ word: I occupies the upper half, Q the lower half.
  localparam int IQ_W      = 32;
  localparam int IQ_HALF_W = 16;
  localparam int IQ_I_LSB  = 16;
  localparam int IQ_Q_LSB  = 0;

  // PRBS15, x^15 + x^14 + 1, Fibonacci form; 16 bits generated per word.
  localparam int PRBS_LEN   = 15;
  localparam int PRBS_TAP_A = 14;
  localparam int PRBS_TAP_B = 13;
  localparam int PRBS_STEPS = 16;

  typedef struct packed {
    logic [PRBS_LEN-1:0]  state;
    logic [IQ_HALF_W-1:0] bits;
  } prbs_step_t;

  // Each generated bit is the feedback value; the first one ends up in bits[15].
  function automatic prbs_step_t prbs15_step16(input logic [PRBS_LEN-1:0] s);
    prbs_step_t r;
    logic       fb;
    r.state = s;
    r.bits  = '0;
    for (int k = 0; k < PRBS_STEPS; k++) begin
      fb      = r.state[PRBS_TAP_A] ^ r.state[PRBS_TAP_B];
      r.state = {r.state[PRBS_LEN-2:0], fb};
      r.bits  = {r.bits[IQ_HALF_W-2:0], fb};
    end
    return r;
  endfunction

  function automatic logic [IQ_W-1:0] iq_pack(input logic [IQ_HALF_W-1:0] i_val,
                                              input logic [IQ_HALF_W-1:0] q_val);
    logic [IQ_W-1:0] w;
    w = '0;
    w[IQ_I_LSB +: IQ_HALF_W] = i_val;
    w[IQ_Q_LSB +: IQ_HALF_W] = q_val;
    return w;
  endfunction

endpackage

// File: rtl/adrv9001_prbs15.sv
// 16-step parallel PRBS15 generator; dout is the next word, state advances
// by a full word on each advance pulse.
module adrv9001_prbs15
  import adrv9001_tx_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] SEED = 15'h7FFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  output logic [IQ_HALF_W-1:0] dout
);

  logic [PRBS_LEN-1:0] state;
  prbs_step_t          nxt;

  assign nxt  = prbs15_step16(state);
  assign dout = nxt.bits;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= SEED;
    end else if (advance) begin
      state <= nxt.state;
    end
  end

endmodule

// File: rtl/adrv9001_tx_data_gen.sv
// ADRV9001 transmit data source: passthrough skid buffer or built-in patterns
// (constant, ramp, PRBS15), with underflow detection and optional zero fill.
module adrv9001_tx_data_gen
  import adrv9001_tx_pkg::*;
#(
  parameter bit                  ZERO_FILL = 1'b1,
  parameter logic [PRBS_LEN-1:0] PRBS_SEED = 15'h7FFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [IQ_W-1:0] const_iq,
  input  logic            clear,
  input  logic [IQ_W-1:0] s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [IQ_W-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            underflow_flag,
  output logic [15:0]     underflow_cnt
);

  tx_mode_e             mode_in, mode_q;
  logic                 out_valid, spare_valid, s_ready_q, armed;
  logic [IQ_W-1:0]      out_data, spare_data, gen_word;
  logic [IQ_HALF_W-1:0] ramp_q, prbs_bits;
  logic                 in_fire, boundary, mode_chg, gen_load, uf_cycle;

  assign mode_in  = tx_mode_e'(mode);
  assign in_fire  = s_axis_tvalid & s_ready_q;
  assign boundary = ~out_valid | m_axis_tready;
  assign mode_chg = boundary & (mode_in != mode_q);
  assign gen_load = boundary & ~mode_chg & (mode_q != TX_MODE_PASS);
  assign uf_cycle = (mode_q == TX_MODE_PASS) & armed & m_axis_tready & ~out_valid & ~spare_valid;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gen_word = '0;
    case (mode_q)
      TX_MODE_CONST: gen_word = const_iq;
      TX_MODE_RAMP:  gen_word = iq_pack(ramp_q, ~ramp_q + 16'd1);
      TX_MODE_PRBS:  gen_word = iq_pack(prbs_bits, ~prbs_bits);
      default:       gen_word = '0;
    endcase
  end

  adrv9001_prbs15 #(.SEED(PRBS_SEED)) u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (mode_chg),
    .advance (gen_load & (mode_q == TX_MODE_PRBS)),
    .dout    (prbs_bits)
  );

  // NOTE: the data registers are reset too, since the output word must read zero during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      spare_valid <= 1'b0;
      spare_data  <= '0;
      s_ready_q   <= 1'b0;
      mode_q      <= TX_MODE_PASS;
      ramp_q      <= '0;
      armed       <= 1'b0;
    end else begin
      if (boundary) mode_q <= mode_in;
      if (mode_chg) begin
        out_valid   <= 1'b0;
        spare_valid <= 1'b0;
        armed       <= 1'b0;
        ramp_q      <= '0;
        s_ready_q   <= 1'b1;
      end else if (mode_q != TX_MODE_PASS) begin
        s_ready_q <= 1'b1;
        if (gen_load) begin
          out_valid <= 1'b1;
          out_data  <= gen_word;
          if (mode_q == TX_MODE_RAMP) ramp_q <= ramp_q + 16'd1;
        end
      end else begin
        if (in_fire) armed <= 1'b1;
        // Ready is only ever high with the spare empty, so input never meets a full spare.
        if (boundary) begin
          if (spare_valid) begin
            out_data    <= spare_data;
            out_valid   <= 1'b1;
            spare_valid <= 1'b0;
          end else begin
            out_valid <= in_fire;
            if (in_fire) out_data <= s_axis_tdata;
          end
          s_ready_q <= 1'b1;
        end else if (in_fire) begin
          spare_data  <= s_axis_tdata;
          spare_valid <= 1'b1;
          s_ready_q   <= 1'b0;
        end
      end
    end
  end

  // An underflow in the same cycle as clear wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_flag <= 1'b0;
      underflow_cnt  <= '0;
    end else if (uf_cycle) begin
      underflow_flag <= 1'b1;
      if (clear)                          underflow_cnt <= 16'd1;
      else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end else if (clear) begin
      underflow_flag <= 1'b0;
      underflow_cnt  <= '0;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = out_valid | (ZERO_FILL & uf_cycle);
  assign m_axis_tdata  = out_valid ? out_data : '0;

endmodule
